// File: rtl/myadder1_arb_pkg.sv
// myadder1_arb_pkg: shared FSM state type, stats width and round-robin pick helper for the packet arbiter
package myadder1_arb_pkg;
  typedef enum logic {IDLE, XFER} arb_state_t;
  localparam int STAT_WIDTH = 32;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;
  function automatic rr_pick_t rr_pick(input logic [7:0] valid, input logic [2:0] last_grant, input int num_ports);
    rr_pick_t r;
    logic [2:0] j;
    r = '0;
    for (int i = 8; i >= 1; i--) begin
      j = 3'((int'(last_grant) + i) % num_ports);
      if (i <= num_ports && valid[j]) r = '{found: 1'b1, idx: j};
    end
    return r;
  endfunction
endpackage

// File: rtl/myadder1_axis_pkt_arbiter_skid.sv
// myadder1_axis_skid_buffer: 2-entry registered skid slice (clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupied)
module myadder1_axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         occupied
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign occupied = out_valid || skid_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_ready || !out_valid) begin
      out_valid  <= skid_valid || accept;
      out_data   <= skid_valid ? skid_data : accept ? in_data : out_data;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/myadder1_axis_pkt_arbiter.sv
// myadder1_axis_pkt_arbiter: packet-granular round-robin AXIS arbiter with tid tagging and skid output (aclk, areset, arb_enable, s_axis_*, m_axis_*, busy; stat_sel/stat_pkt_count with MYADDER1_ARB_STATS_EN)
module myadder1_axis_pkt_arbiter
  import myadder1_arb_pkg::*;
#(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ID_WIDTH         = 2
) (
  input  logic                                      aclk,
  input  logic                                      areset,
  input  logic                                      arb_enable,
  input  logic [C_NUM_PORTS-1:0]                    s_axis_tvalid,
  output logic [C_NUM_PORTS-1:0]                    s_axis_tready,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_PORTS-1:0]                    s_axis_tlast,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                                      m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]                     m_axis_tid,
  output logic                                      busy
`ifdef MYADDER1_ARB_STATS_EN
  ,
  input  logic [C_ID_WIDTH-1:0]                     stat_sel,
  output logic [STAT_WIDTH-1:0]                     stat_pkt_count
`endif
);
  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int KW = W / 8;
  localparam int PW = C_ID_WIDTH + 1 + KW + W;
  arb_state_t            state, state_n;
  logic [C_ID_WIDTH-1:0] grant, last_grant;
  rr_pick_t              pick;
  logic                  sk_ready, sk_occ, in_valid, beat, beat_last, start;
  logic [PW-1:0]         sk_in, sk_out;
  always_comb begin
    pick          = rr_pick(8'(s_axis_tvalid), 3'(last_grant), C_NUM_PORTS);
    in_valid      = state == XFER && s_axis_tvalid[grant];
    beat          = in_valid && sk_ready;
    beat_last     = beat && s_axis_tlast[grant];
    start         = state == IDLE && arb_enable && pick.found;
    state_n       = start ? XFER : beat_last ? IDLE : state;
    s_axis_tready = (state == XFER && sk_ready) ? C_NUM_PORTS'(1) << grant : '0;
    sk_in         = {grant, s_axis_tlast[grant], s_axis_tkeep[grant*KW +: KW], s_axis_tdata[grant*W +: W]};
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= C_ID_WIDTH'(C_NUM_PORTS - 1);
    end else begin
      state <= state_n;
      if (start) grant <= C_ID_WIDTH'(pick.idx);
      if (beat_last) last_grant <= grant;
    end
  end
  myadder1_axis_skid_buffer #(.W(PW)) u_skid (
    .clk       (aclk),
    .rst       (areset),
    .in_valid  (in_valid),
    .in_ready  (sk_ready),
    .in_data   (sk_in),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (sk_out),
    .occupied  (sk_occ)
  );
  assign {m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = sk_out;
  assign busy = state == XFER || sk_occ;
`ifdef MYADDER1_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] pkt_cnt [C_NUM_PORTS];
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < C_NUM_PORTS; i++) pkt_cnt[i] <= '0;
    end else if (beat_last && pkt_cnt[grant] != '1) begin
      pkt_cnt[grant] <= pkt_cnt[grant] + 1'b1;
    end
  end
  assign stat_pkt_count = int'(stat_sel) < C_NUM_PORTS ? pkt_cnt[stat_sel] : '0;
`endif
endmodule
